// File: rtl/usb_rx_pkt_ctrl.sv
// -----------------------------------------------------------------------------
// usb_rx_pkt_ctrl
//
// Packet-level receive controller for a USB full-speed receiver. It sits
// between the byte deserialiser / EOP detector and the RX FIFO / CRC checkers.
// It checks the SYNC byte and PID, classifies the packet (token, data,
// handshake) and enforces length limits. On data packets it holds back the
// last two bytes so the trailing CRC16 is never forwarded. It waits for the
// CRC verdict, then reports done or error with a cause code.
//
// Optional feature (compile-time macro USB_RX_WATCHDOG_EN):
//   When defined, an idle-bus watchdog aborts a packet with code 6 if no
//   byte_valid or eop arrives for WDOG_CYCLES clocks outside IDLE.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   d_edge          data-line transition (starts a packet from IDLE)
//   rx_byte         deserialised byte, qualified by byte_valid (1-cycle pulse)
//   eop             end-of-packet pulse
//   crc_ok/crc_err  verdict from the selected CRC checker
//   rx_active       packet in progress (state != IDLE)
//   enable_timer    bit-timer enable while bytes are expected
//   crc_sel         0 = CRC5 (token), 1 = CRC16 (data)
//   crc_clear       one-cycle pulse reseeding the CRC checkers
//   load_pid        one-cycle pulse, pid_out valid
//   pid_out         decoded PID nibble
//   data_out        payload byte, qualified by data_valid (1-cycle pulse)
//   byte_count      payload bytes emitted in the current packet
//   rx_done         one-cycle pulse, packet accepted
//   rx_error        one-cycle pulse, packet rejected
//   err_code        rejection cause, held until the next packet starts
//
// Error codes: 1 bad SYNC, 2 PID check, 3 unsupported PID, 4 length,
//              5 CRC fail/timeout, 6 watchdog, 7 early eop.
// -----------------------------------------------------------------------------
module usb_rx_pkt_ctrl #(
    parameter int MAX_DATA_BYTES = 64,
    parameter int CNT_W          = $clog2(MAX_DATA_BYTES + 1),
    parameter int CRC_WAIT       = 4,
    parameter int WDOG_CYCLES    = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_edge,
    input  logic [7:0]       rx_byte,
    input  logic             byte_valid,
    input  logic             eop,
    input  logic             crc_ok,
    input  logic             crc_err,
    output logic             rx_active,
    output logic             enable_timer,
    output logic             crc_sel,
    output logic             crc_clear,
    output logic             load_pid,
    output logic [3:0]       pid_out,
    output logic [7:0]       data_out,
    output logic             data_valid,
    output logic [CNT_W-1:0] byte_count,
    output logic             rx_done,
    output logic             rx_error,
    output logic [2:0]       err_code
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_TOKEN,
        ST_DATA,
        ST_HSHK,
        ST_CHECK,
        ST_ERROR,
        ST_DONE
    } state_t;

    localparam logic [2:0] ERR_SYNC  = 3'd1;
    localparam logic [2:0] ERR_PID   = 3'd2;
    localparam logic [2:0] ERR_TYPE  = 3'd3;
    localparam logic [2:0] ERR_LEN   = 3'd4;
    localparam logic [2:0] ERR_CRC   = 3'd5;
    localparam logic [2:0] ERR_EOP   = 3'd7;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    localparam int CHK_W = (CRC_WAIT > 1) ? $clog2(CRC_WAIT) : 1;

    state_t           state_q, state_d;
    logic [1:0]       rx_cnt_q, rx_cnt_d;      // bytes held (DATA) or seen (TOKEN)
    logic [7:0]       hb0_q, hb0_d;            // oldest held byte
    logic [7:0]       hb1_q, hb1_d;            // newest held byte
    logic [CHK_W-1:0] chk_cnt_q, chk_cnt_d;
    logic [CNT_W-1:0] byte_count_q, byte_count_d;
    logic [2:0]       err_code_q, err_code_d;
    logic             crc_sel_q, crc_sel_d;
    logic             crc_clear_q, crc_clear_d;
    logic             load_pid_q, load_pid_d;
    logic [3:0]       pid_out_q, pid_out_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             pid_ok;
    logic             wdog_hit;

    assign pid_ok = (rx_byte[7:4] == ~rx_byte[3:0]);

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned (which would infer a latch); blocking '=' is correct
        // here because this block describes combinational logic.
        state_d      = state_q;
        rx_cnt_d     = rx_cnt_q;
        hb0_d        = hb0_q;
        hb1_d        = hb1_q;
        chk_cnt_d    = chk_cnt_q;
        byte_count_d = byte_count_q;
        err_code_d   = err_code_q;
        crc_sel_d    = crc_sel_q;
        pid_out_d    = pid_out_q;
        data_out_d   = data_out_q;
        crc_clear_d  = 1'b0;
        load_pid_d   = 1'b0;
        data_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (d_edge) begin
                    state_d      = ST_SYNC;
                    crc_clear_d  = 1'b1;
                    err_code_d   = '0;
                    byte_count_d = '0;
                    rx_cnt_d     = '0;
                    chk_cnt_d    = '0;
                end
            end

            ST_SYNC: begin
                if (byte_valid) begin
                    if (rx_byte != SYNC_BYTE) begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_SYNC;
                    end else if (eop) begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_EOP;
                    end else begin
                        state_d = ST_PID;
                    end
                end else if (eop) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_EOP;
                end
            end

            ST_PID: begin
                if (byte_valid) begin
                    if (!pid_ok) begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_PID;
                    end else begin
                        load_pid_d = 1'b1;
                        pid_out_d  = rx_byte[3:0];
                        // An eop on the PID byte itself is judged as the
                        // end of an empty packet of the decoded type.
                        case (rx_byte[3:0])
                            4'b0001, 4'b1001, 4'b1101, 4'b0101: begin
                                crc_sel_d  = 1'b0;
                                state_d    = eop ? ST_ERROR : ST_TOKEN;
                                err_code_d = eop ? ERR_LEN : err_code_q;
                            end
                            4'b0011, 4'b1011: begin
                                crc_sel_d  = 1'b1;
                                state_d    = eop ? ST_ERROR : ST_DATA;
                                err_code_d = eop ? ERR_LEN : err_code_q;
                            end
                            4'b0010, 4'b1010, 4'b1110: begin
                                crc_sel_d = 1'b0;
                                state_d   = eop ? ST_DONE : ST_HSHK;
                            end
                            default: begin
                                state_d    = ST_ERROR;
                                err_code_d = ERR_TYPE;
                            end
                        endcase
                    end
                end else if (eop) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_EOP;
                end
            end

            ST_TOKEN: begin
                if (byte_valid) begin
                    if (rx_cnt_q == 2'd2) begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_LEN;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 2'd1;
                    end
                end
                // eop is judged after any same-cycle byte has been counted.
                if (eop && state_d == ST_TOKEN) begin
                    if (rx_cnt_d == 2'd2) begin
                        state_d   = ST_CHECK;
                        chk_cnt_d = '0;
                    end else begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_LEN;
                    end
                end
            end

            ST_DATA: begin
                if (byte_valid) begin
                    if (rx_cnt_q == 2'd2) begin
                        // Buffer full: the oldest byte is known to be payload.
                        if (byte_count_q == CNT_W'(MAX_DATA_BYTES)) begin
                            state_d    = ST_ERROR;
                            err_code_d = ERR_LEN;
                        end else begin
                            data_out_d   = hb0_q;
                            data_valid_d = 1'b1;
                            byte_count_d = byte_count_q + 1'b1;
                            hb0_d        = hb1_q;
                            hb1_d        = rx_byte;
                        end
                    end else begin
                        if (rx_cnt_q == 2'd0) begin
                            hb0_d = rx_byte;
                        end else begin
                            hb1_d = rx_byte;
                        end
                        rx_cnt_d = rx_cnt_q + 2'd1;
                    end
                end
                // The two bytes still held at eop are the CRC16.
                if (eop && state_d == ST_DATA) begin
                    if (rx_cnt_d == 2'd2) begin
                        state_d   = ST_CHECK;
                        chk_cnt_d = '0;
                    end else begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_LEN;
                    end
                end
            end

            ST_HSHK: begin
                if (byte_valid) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_LEN;
                end else if (eop) begin
                    state_d = ST_DONE;
                end
            end

            ST_CHECK: begin
                // crc_err is tested first so it wins over a coincident crc_ok.
                if (crc_err) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_CRC;
                end else if (crc_ok) begin
                    state_d = ST_DONE;
                end else if (chk_cnt_q == CHK_W'(CRC_WAIT - 1)) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_CRC;
                end else begin
                    chk_cnt_d = chk_cnt_q + 1'b1;
                end
            end

            ST_ERROR: state_d = ST_IDLE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Watchdog only fires when nothing else moved the FSM this cycle.
        if (wdog_hit && state_d == state_q && state_q != ST_IDLE) begin
            state_d    = ST_ERROR;
            err_code_d = 3'd6;
        end
    end

    // -------------------------------------------------------------------------
    // Optional idle-bus watchdog
    // -------------------------------------------------------------------------
`ifdef USB_RX_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;

    assign wdog_hit = (wdog_cnt_q == WDOG_W'(WDOG_CYCLES));

    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        if (state_q == ST_IDLE || byte_valid || eop) begin
            wdog_cnt_d = '0;
        end else if (!wdog_hit) begin
            wdog_cnt_d = wdog_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt_q <= '0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
        end
    end
`else
    assign wdog_hit = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // State and control registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking '<=' so every flop samples the
    // values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rx_cnt_q     <= '0;
            chk_cnt_q    <= '0;
            byte_count_q <= '0;
            err_code_q   <= '0;
            crc_sel_q    <= 1'b0;
            crc_clear_q  <= 1'b0;
            load_pid_q   <= 1'b0;
            pid_out_q    <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_cnt_q     <= rx_cnt_d;
            chk_cnt_q    <= chk_cnt_d;
            byte_count_q <= byte_count_d;
            err_code_q   <= err_code_d;
            crc_sel_q    <= crc_sel_d;
            crc_clear_q  <= crc_clear_d;
            load_pid_q   <= load_pid_d;
            pid_out_q    <= pid_out_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    // NOTE: the holdback bytes are storage, not control; they are left
    // unreset because rx_cnt_q (which is reset) says whether they are valid.
    always_ff @(posedge clk) begin
        hb0_q <= hb0_d;
        hb1_q <= hb1_d;
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign rx_active    = (state_q != ST_IDLE);
    assign enable_timer = (state_q == ST_SYNC) || (state_q == ST_PID) ||
                          (state_q == ST_TOKEN) || (state_q == ST_DATA) ||
                          (state_q == ST_HSHK);
    assign rx_done      = (state_q == ST_DONE);
    assign rx_error     = (state_q == ST_ERROR);
    assign crc_sel      = crc_sel_q;
    assign crc_clear    = crc_clear_q;
    assign load_pid     = load_pid_q;
    assign pid_out      = pid_out_q;
    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign byte_count   = byte_count_q;
    assign err_code     = err_code_q;

endmodule
